chain_fk: RTL and testbench
===========================

# chain_fk

- Parametrised forward-kinematics chain sequencer; generational successor to the fixed six-joint cumulative-transform block.
- Computes the cumulative transforms T_0k = A_1·…·A_k for a configurable number of joints, under its own FSM with valid/ready handshakes. It does not depend on an externally driven global count.
- Sits between the Jacobian controller and two shared engines: the DH transform generator (t_block) and the 4×4 matrix multiplier. It publishes every frame matrix plus per-frame valid flags.

## Interface
Parameters:
- N_JOINTS, 6, number of DH links processed per run (1..16).
- W, 27, signed fixed-point width of every matrix element.
- PW, 21, signed width of each DH parameter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  global advance enable; when low, all state and outputs hold.
- start  in  1  one-cycle run request; sampled in IDLE only.
- dh_param  in  N_JOINTS×4×PW  per-joint {theta, a, d, alpha}, packed by index constants THETA=0, A_PARAM=1, D_PARAM=2, ALPHA=3.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at end of run.
- tb_req_valid / tb_req_ready  out/in  1/1  DH generator request handshake.
- tb_theta, tb_a, tb_d, tb_alpha  out  PW each  DH operands for the current joint; stable while tb_req_valid is high.
- tb_resp_valid  in  1  generator result strobe.
- tb_matrix  in  4×4×W  generator result.
- mm_req_valid / mm_req_ready  out/in  1/1  multiplier request handshake.
- mm_dataa, mm_datab  out  4×4×W each  operands; product is dataa·datab.
- mm_resp_valid  in  1  product strobe.
- mm_result  in  4×4×W  product; already scaled back to W.
- frame  out  N_JOINTS×4×4×W  frame[k] = T_0(k+1).
- frame_valid  out  N_JOINTS  bit k set once frame[k] is written in the current run.

## Operation
- States: IDLE, REQ_T, WAIT_T, REQ_M, WAIT_M, NEXT, DONE. Joint index k has width $clog2(N_JOINTS)+1.
- IDLE: when start and en are both high, go to REQ_T with k=0 and frame_valid cleared. frame contents are retained.
- REQ_T: drive tb_req_valid=1 and tb_* = dh_param[k]. When tb_req_ready is high, go to WAIT_T.
- WAIT_T: on tb_resp_valid, latch tb_matrix into t_reg.
  - k==0: frame[0] ← tb_matrix, acc ← tb_matrix, go to NEXT.
  - Otherwise: go to REQ_M.
- REQ_M: drive mm_req_valid=1, mm_dataa=acc, mm_datab=t_reg. When mm_req_ready is high, go to WAIT_M.
- WAIT_M: on mm_resp_valid, frame[k] ← mm_result, acc ← mm_result, go to NEXT.
- NEXT: set frame_valid[k].
  - k==N_JOINTS-1: go to DONE.
  - Otherwise: k++ and go to REQ_T.
- DONE: done=1 for one cycle, then IDLE.
- Response strobes arriving outside the matching WAIT state are ignored.
- start while busy is ignored; no queueing.
- N_JOINTS==1: no multiplier request is ever issued.
- en low: the FSM freezes, req_valid outputs hold their value, and incoming strobes are ignored. Engines must hold their strobe until en returns.
- No arithmetic is performed in this block. Widths pass through unchanged; no truncation or saturation.

## Timing
- Reset values: busy=0, done=0, tb_req_valid=0, mm_req_valid=0, tb_* = 0, mm_data* = 0, frame = 0, frame_valid = 0, state = IDLE, k = 0.
- Reset mid-run: the next cycle is IDLE with every register above at its reset value. In-flight engine responses are dropped.
- Latency: assume always-ready engines with response latencies Lt and Lm (each ≥1), and start sampled at edge 0. done is high in cycle 1 + N·(2+Lt) + (N−1)·(1+Lm).
  - N=6, Lt=Lm=1: done in cycle 29.
- Each frame_valid[k] rises exactly one cycle after frame[k] is written.
- Ready low stretches REQ_T or REQ_M; operands stay stable for that whole time.

## Structure
- Package chain_fk_pkg:
  - mat4_t (4×4×W signed);
  - dh_t;
  - state enum;
  - THETA/A_PARAM/D_PARAM/ALPHA constants.
- Single module; frame storage and FSM inline. No sub-module is required.

## Test plan
- Identity chain (all DH params zero, model returns I): N=6, Lt=Lm=1 → done in cycle 29, all six frames = I, frame_valid = 6'h3F.
- Pure translations: a_k = k in Q-format, alpha = theta = 0 → frame[5] translation x = 21.0, rotation = I.
- Backpressure: tb_req_ready and mm_req_ready random at 50% → identical frames to the zero-stall run; operands stable while valid is high and ready is low.
- Run with N_JOINTS=1 → mm_req_valid never asserts; done in cycle 1+2+Lt.
- rst low during WAIT_M of k=3 → next cycle all outputs at reset values; a fresh start completes correctly.
- start pulsed while busy and en toggled low for 5 cycles mid-run → second start ignored; done delayed exactly 5 cycles; frames unchanged.

Source files
------------

// File: rtl/chain_fk_pkg.sv
// Shared types and constants for the forward-kinematics chain sequencer.
// Matrix and DH widths here are the defaults; chain_fk re-derives them from its parameters.
package chain_fk_pkg;

   localparam int MAT_W = 27;
   localparam int DH_W  = 21;

   localparam logic [1:0] THETA   = 2'd0;
   localparam logic [1:0] A_PARAM = 2'd1;
   localparam logic [1:0] D_PARAM = 2'd2;
   localparam logic [1:0] ALPHA   = 2'd3;

   typedef logic signed [3:0][3:0][MAT_W-1:0] mat4_t;

   typedef struct packed {
      logic signed [DH_W-1:0] alpha;
      logic signed [DH_W-1:0] d;
      logic signed [DH_W-1:0] a;
      logic signed [DH_W-1:0] theta;
   } dh_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_T  = 3'd1,
      WAIT_T = 3'd2,
      REQ_M  = 3'd3,
      WAIT_M = 3'd4,
      NEXT   = 3'd5,
      DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/chain_fk.sv
// Forward-kinematics chain sequencer: drives the DH generator and matrix multiplier
// to build T_0k = A_1*...*A_k for every joint and publishes all frames.
module chain_fk
   import chain_fk_pkg::*;
#(
   parameter int N_JOINTS = 6,
   parameter int W        = MAT_W,
   parameter int PW       = DH_W
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    en,
   input  logic                                    start,
   input  logic [N_JOINTS-1:0][3:0][PW-1:0]        dh_param,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    tb_req_valid,
   input  logic                                    tb_req_ready,
   output logic [PW-1:0]                           tb_theta,
   output logic [PW-1:0]                           tb_a,
   output logic [PW-1:0]                           tb_d,
   output logic [PW-1:0]                           tb_alpha,
   input  logic                                    tb_resp_valid,
   input  logic [3:0][3:0][W-1:0]                  tb_matrix,
   output logic                                    mm_req_valid,
   input  logic                                    mm_req_ready,
   output logic [3:0][3:0][W-1:0]                  mm_dataa,
   output logic [3:0][3:0][W-1:0]                  mm_datab,
   input  logic                                    mm_resp_valid,
   input  logic [3:0][3:0][W-1:0]                  mm_result,
   output logic [N_JOINTS-1:0][3:0][3:0][W-1:0]    frame,
   output logic [N_JOINTS-1:0]                     frame_valid
);

   localparam int KW = $clog2(N_JOINTS) + 1;

   state_t                               r_state;
   state_t                               w_state_nxt;
   logic [KW-1:0]                        r_k;
   logic [3:0][3:0][W-1:0]               r_acc;
   logic [3:0][3:0][W-1:0]               r_t;
   logic [N_JOINTS-1:0][3:0][3:0][W-1:0] r_frame;
   logic [N_JOINTS-1:0]                  r_frame_valid;
   logic                                 w_first;
   logic                                 w_last;

   assign w_first     = (r_k == KW'(0));
   assign w_last      = (r_k == KW'(N_JOINTS - 1));
   assign frame       = r_frame;
   assign frame_valid = r_frame_valid;

   // State register; en low freezes the sequencer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else if (en) begin
         r_state <= w_state_nxt;
      end else begin
         r_state <= r_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = start         ? REQ_T : IDLE;
         REQ_T:   w_state_nxt = tb_req_ready  ? WAIT_T : REQ_T;
         WAIT_T:  begin
            if (tb_resp_valid) begin
               w_state_nxt = w_first ? NEXT : REQ_M;
            end else begin
               w_state_nxt = WAIT_T;
            end
         end
         REQ_M:   w_state_nxt = mm_req_ready  ? WAIT_M : REQ_M;
         WAIT_M:  w_state_nxt = mm_resp_valid ? NEXT : WAIT_M;
         NEXT:    w_state_nxt = w_last        ? DONE : REQ_T;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode; operands come from held registers so they stay stable under backpressure
   always_comb begin
      busy         = (r_state != IDLE);
      done         = (r_state == DONE);
      tb_req_valid = (r_state == REQ_T);
      mm_req_valid = (r_state == REQ_M);
      tb_theta     = '0;
      tb_a         = '0;
      tb_d         = '0;
      tb_alpha     = '0;
      if (r_state == REQ_T) begin
         for (int j = 0; j < N_JOINTS; j++) begin
            if (r_k == KW'(j)) begin
               tb_theta = dh_param[j][THETA];
               tb_a     = dh_param[j][A_PARAM];
               tb_d     = dh_param[j][D_PARAM];
               tb_alpha = dh_param[j][ALPHA];
            end else begin
               tb_theta = tb_theta;
            end
         end
      end else begin
         tb_theta = '0;
      end
      if (r_state == REQ_M) begin
         mm_dataa = r_acc;
         mm_datab = r_t;
      end else begin
         mm_dataa = '0;
         mm_datab = '0;
      end
   end

   // Joint index, operand latches and frame storage
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_k           <= '0;
         r_acc         <= '0;
         r_t           <= '0;
         r_frame       <= '0;
         r_frame_valid <= '0;
      end else if (en) begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_k           <= KW'(0);
                  r_frame_valid <= '0;
               end
            end
            WAIT_T: begin
               if (tb_resp_valid) begin
                  r_t <= tb_matrix;
                  if (w_first) begin
                     r_frame[0] <= tb_matrix;
                     r_acc      <= tb_matrix;
                  end
               end
            end
            WAIT_M: begin
               if (mm_resp_valid) begin
                  r_acc <= mm_result;
                  for (int j = 0; j < N_JOINTS; j++) begin
                     if (r_k == KW'(j)) r_frame[j] <= mm_result;
                  end
               end
            end
            NEXT: begin
               for (int j = 0; j < N_JOINTS; j++) begin
                  if (r_k == KW'(j)) r_frame_valid[j] <= 1'b1;
               end
               if (!w_last) r_k <= r_k + KW'(1);
            end
            default: begin
               r_k <= r_k;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chain_fk.sv
// Scoreboard bench for chain_fk: behavioural DH generator / multiplier engines,
// expected operands and frames queued at start, compared as the DUT produces them.
module tb_chain_fk;

   localparam int N  = 6;
   localparam int W  = 27;
   localparam int PW = 21;
   localparam int F  = 16;

   typedef logic [15:0][W-1:0]    mat_t;
   typedef logic [N-1:0][15:0][W-1:0] frames_t;
   typedef logic [3:0][PW-1:0]    dh_row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, start;
   logic [N-1:0][3:0][PW-1:0] dh;
   logic busy, done, tb_req_valid, tb_req_ready, tb_resp_valid;
   logic [PW-1:0] tb_theta, tb_a, tb_d, tb_alpha;
   mat_t tb_matrix, mm_dataa, mm_datab, mm_result;
   logic mm_req_valid, mm_req_ready, mm_resp_valid;
   frames_t frame;
   logic [N-1:0] frame_valid;
   dh_row_t tb_ops;
   assign tb_ops = {tb_alpha, tb_d, tb_a, tb_theta};

   logic start1;
   logic [0:0][3:0][PW-1:0] dh1;
   logic busy1, done1, tv1, tr1, resp1, mv1, mr1, mrv1;
   logic [PW-1:0] th1, a1, d1, al1;
   mat_t mat1, mda1, mdb1, mres1;
   logic [0:0][15:0][W-1:0] frame1;
   logic [0:0] fv1;

   chain_fk #(.N_JOINTS(N), .W(W), .PW(PW)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .dh_param(dh),
      .busy(busy), .done(done), .tb_req_valid(tb_req_valid), .tb_req_ready(tb_req_ready),
      .tb_theta(tb_theta), .tb_a(tb_a), .tb_d(tb_d), .tb_alpha(tb_alpha),
      .tb_resp_valid(tb_resp_valid), .tb_matrix(tb_matrix),
      .mm_req_valid(mm_req_valid), .mm_req_ready(mm_req_ready),
      .mm_dataa(mm_dataa), .mm_datab(mm_datab), .mm_resp_valid(mm_resp_valid),
      .mm_result(mm_result), .frame(frame), .frame_valid(frame_valid));

   chain_fk #(.N_JOINTS(1), .W(W), .PW(PW)) dut1 (
      .clk(clk), .rst(rst), .en(1'b1), .start(start1), .dh_param(dh1),
      .busy(busy1), .done(done1), .tb_req_valid(tv1), .tb_req_ready(tr1),
      .tb_theta(th1), .tb_a(a1), .tb_d(d1), .tb_alpha(al1),
      .tb_resp_valid(resp1), .tb_matrix(mat1),
      .mm_req_valid(mv1), .mm_req_ready(mr1),
      .mm_dataa(mda1), .mm_datab(mdb1), .mm_resp_valid(mrv1),
      .mm_result(mres1), .frame(frame1), .frame_valid(fv1));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sin/cos of q quarter turns as -1/0/1
   function automatic int qtrig(input int q, input bit is_sin);
      int r;
      r = is_sin ? ((q + 3) & 3) : (q & 3);
      case (r)
         0:       return 1;
         2:       return -1;
         default: return 0;
      endcase
   endfunction

   // DH link A = Rz(theta) Tz(d) Tx(a) Rx(alpha); angles are quarter turns in the low bits
   function automatic mat_t gen_dh(input dh_row_t p);
      longint one, a, d;
      int ct, st, ca, sa;
      longint v[16];
      mat_t m;
      one = longint'(1) <<< F;
      a   = longint'(signed'(p[1]));
      d   = longint'(signed'(p[2]));
      ct  = qtrig(int'(p[0][1:0]), 1'b0);
      st  = qtrig(int'(p[0][1:0]), 1'b1);
      ca  = qtrig(int'(p[3][1:0]), 1'b0);
      sa  = qtrig(int'(p[3][1:0]), 1'b1);
      v = '{ct * one, -st * ca * one, st * sa * one, ct * a,
            st * one,  ct * ca * one, -ct * sa * one, st * a,
            0,         sa * one,      ca * one,       d,
            0,         0,             0,              one};
      for (int i = 0; i < 16; i++) m[i] = W'(v[i]);
      return m;
   endfunction

   function automatic mat_t mat_mul(input mat_t x, input mat_t y);
      mat_t m;
      longint s;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int i = 0; i < 4; i++)
               s += longint'(signed'(x[r*4+i])) * longint'(signed'(y[i*4+c]));
            m[r*4+c] = W'(s >>> F);
         end
      end
      return m;
   endfunction

   // scoreboard queues
   dh_row_t dh_q[$];
   mat_t    ma_q[$], mb_q[$];
   frames_t frames_q[$];
   int      done_q[$];

   int edge_cnt = 0;
   int runs_done = 0, n1_done = 0, m_hs = 0, exp1_edge = 0, lm = 1;
   bit bp = 1'b0, mm1_seen = 1'b0;
   mat_t exp1_frame;

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   task automatic push_run(input int exp_edge);
      mat_t acc, t;
      frames_t fr;
      for (int k = 0; k < N; k++) begin
         t = gen_dh(dh[k]);
         dh_q.push_back(dh[k]);
         if (k == 0) begin
            acc = t;
         end else begin
            ma_q.push_back(acc);
            mb_q.push_back(t);
            acc = mat_mul(acc, t);
         end
         fr[k] = acc;
      end
      frames_q.push_back(fr);
      done_q.push_back(exp_edge);
   endtask

   task automatic start_run(input int lat);
      push_run(lat < 0 ? -1 : edge_cnt + lat);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_runs(input int n);
      for (int i = 0; i < 3000 && runs_done < n; i++) begin
         @(posedge clk); #1;
      end
      check_eq("run_timeout", 512'(runs_done), 512'(n));
   endtask

   // Engines and monitors, all evaluated on the falling edge
   dh_row_t l_ops, l_ops1;
   mat_t l_da, l_db, pend_t, pend_m;
   frames_t l_frame, fr_exp;
   logic [N-1:0] l_fv;
   logic l_rst = 1'b0, l_en, l_tv, l_tr, l_trv, l_mv, l_mr, l_mrv, l_tv1;
   int t_cnt = 0, m_cnt = 0, ed;

   initial begin
      tb_req_ready = 1'b1; tb_resp_valid = 1'b0; tb_matrix = '0;
      mm_req_ready = 1'b1; mm_resp_valid = 1'b0; mm_result = '0;
      tr1 = 1'b1; resp1 = 1'b0; mat1 = '0; mr1 = 1'b1; mrv1 = 1'b0; mres1 = '0;
      forever begin
         @(negedge clk);
         if (!l_rst) begin
            t_cnt = 0; m_cnt = 0;
            tb_resp_valid = 1'b0; mm_resp_valid = 1'b0; resp1 = 1'b0;
         end else begin
            if (l_trv && l_en) tb_resp_valid = 1'b0;
            if (l_mrv && l_en) mm_resp_valid = 1'b0;
            if (l_tv && l_tr && l_en) begin
               if (dh_q.size() == 0) check_eq("tb_req_unexpected", 512'(dh_q.size()), 512'(1));
               else check_eq("tb_operands", 512'(l_ops), 512'(dh_q.pop_front()));
               pend_t = gen_dh(l_ops);
               t_cnt  = 1;
            end else if (l_tv) begin
               check_eq("tb_req_hold", 512'({tb_req_valid, tb_ops}), 512'({1'b1, l_ops}));
            end
            if (l_mv && l_mr && l_en) begin
               if (ma_q.size() == 0) check_eq("mm_req_unexpected", 512'(ma_q.size()), 512'(1));
               else begin
                  check_eq("mm_dataa", 512'(l_da), 512'(ma_q.pop_front()));
                  check_eq("mm_datab", 512'(l_db), 512'(mb_q.pop_front()));
               end
               pend_m = mat_mul(l_da, l_db);
               m_cnt  = lm;
               m_hs++;
            end else if (l_mv) begin
               check_eq("mm_req_hold", 512'({mm_req_valid, mm_dataa}), 512'({1'b1, l_da}));
               check_eq("mm_datab_hold", 512'(mm_datab), 512'(l_db));
            end
            if (t_cnt > 0) begin
               t_cnt--;
               if (t_cnt == 0) begin tb_resp_valid = 1'b1; tb_matrix = pend_t; end
            end
            if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0) begin mm_resp_valid = 1'b1; mm_result = pend_m; end
            end
            resp1 = l_tv1;
            if (l_tv1) mat1 = gen_dh(l_ops1);
         end
         // frame[k] must already hold its final value a cycle before frame_valid[k] rises
         for (int k = 0; k < N; k++) begin
            if (frame_valid[k] && !l_fv[k] && frames_q.size() > 0) begin
               fr_exp = frames_q[0];
               check_eq($sformatf("fv_rise_frame%0d", k), 512'(frame[k]), 512'(fr_exp[k]));
               check_eq($sformatf("fv_prev_frame%0d", k), 512'(l_frame[k]), 512'(fr_exp[k]));
            end
         end
         if (done) begin
            if (frames_q.size() == 0) begin
               check_eq("done_unexpected", 512'(frames_q.size()), 512'(1));
            end else begin
               fr_exp = frames_q.pop_front();
               ed = done_q.pop_front();
               if (ed >= 0) check_eq("done_cycle", 512'(edge_cnt), 512'(ed));
               for (int k = 0; k < N; k++)
                  check_eq($sformatf("frame%0d", k), 512'(frame[k]), 512'(fr_exp[k]));
               check_eq("frame_valid", 512'(frame_valid), 512'(6'h3F));
               runs_done++;
            end
         end
         if (mv1) mm1_seen = 1'b1;
         if (done1) begin
            check_eq("n1_done_cycle", 512'(edge_cnt), 512'(exp1_edge));
            check_eq("n1_frame", 512'(frame1[0]), 512'(exp1_frame));
            check_eq("n1_frame_valid", 512'(fv1), 512'(1'b1));
            n1_done++;
         end
         tb_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         mm_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         l_rst = rst; l_en = en;
         l_tv = tb_req_valid; l_tr = tb_req_ready; l_trv = tb_resp_valid; l_ops = tb_ops;
         l_mv = mm_req_valid; l_mr = mm_req_ready; l_mrv = mm_resp_valid;
         l_da = mm_dataa; l_db = mm_datab;
         l_frame = frame; l_fv = frame_valid;
         l_tv1 = tv1 && tr1; l_ops1 = {al1, d1, a1, th1};
      end
   end

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ctl"}, 512'({busy, done, tb_req_valid, mm_req_valid}), 512'(4'b0000));
      check_eq({tag, "_fv"}, 512'(frame_valid), 512'(6'h00));
      check_eq({tag, "_tbops"}, 512'(tb_ops), 512'(0));
      check_eq({tag, "_mmops"}, 512'({mm_dataa, mm_datab}), 512'(0));
      for (int k = 0; k < N; k++)
         check_eq($sformatf("%s_frame%0d", tag, k), 512'(frame[k]), 512'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b1; start = 1'b0; start1 = 1'b0; dh = '0;
      dh1[0] = {PW'(1), PW'(2 << F), PW'(3 << F), PW'(1)};
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      check_eq("n1_reset", 512'({busy1, done1, tv1, mv1, fv1}), 512'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // identity chain, plus the single-joint instance started alongside
      exp1_frame = gen_dh(dh1[0]);
      exp1_edge  = edge_cnt + 4;
      start1 = 1'b1;
      start_run(29);
      start1 = 1'b0;
      wait_runs(1);

      // pure translations along x: a_k = k
      for (int k = 0; k < N; k++) dh[k] = {PW'(0), PW'(0), PW'((k + 1) << F), PW'(0)};
      start_run(29);
      wait_runs(2);
      check_eq("x_translation", 512'(frame[5][3]), 512'(27'(21 << F)));
      check_eq("rotation_id", 512'({frame[5][0], frame[5][5], frame[5][10], frame[5][1]}),
               512'({27'(1 << F), 27'(1 << F), 27'(1 << F), 27'(0)}));

      // mixed rotations: zero-stall then 50% backpressure, same expected frames
      for (int k = 0; k < N; k++)
         dh[k] = {PW'((k * 3) & 3), PW'(k << F), PW'((k + 1) << F), PW'(k & 3)};
      start_run(29);
      wait_runs(3);
      bp = 1'b1;
      start_run(-1);
      wait_runs(4);
      bp = 1'b0;

      // reset while waiting on the multiplier for k=3
      lm = 3; m_hs = 0;
      start_run(-1);
      for (int i = 0; i < 200 && m_hs < 3; i++) begin
         @(posedge clk); #1;
      end
      check_eq("reach_wait_m3", 512'(m_hs), 512'(3));
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_state("midrun_reset");
      rst = 1'b1;
      dh_q.delete(); ma_q.delete(); mb_q.delete(); frames_q.delete(); done_q.delete();
      lm = 1;
      @(posedge clk); #1;
      start_run(29);
      wait_runs(5);

      // start while busy is ignored; en low for 5 cycles delays done by 5
      start_run(34);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      wait_runs(6);

      repeat (3) @(posedge clk);
      #1;
      check_eq("n1_no_mm_req", 512'(mm1_seen), 512'(1'b0));
      check_eq("n1_run_count", 512'(n1_done), 512'(1));
      check_eq("queues_drained", 512'(dh_q.size() + ma_q.size() + frames_q.size()), 512'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
